// File: rtl/spi_flash_reader_pkg.sv
// Shared types and constants for the SPI flash burst reader.
// Holds FSM state encodings, the READ opcode and the SPI bit timing.
package spi_flash_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    localparam logic [7:0] SPI_READ_OP = 8'h03;

    // spi_clk cycles per SPI bit (one low phase, one high phase)
    localparam int BIT_CYC = 2;

endpackage

// File: rtl/spi_flash_reader_shift8.sv
// 8-bit SPI mode-0 shift engine: shifts tx_byte out MSB first on mosi and
// collects miso into rx_byte. Ports: load/tx_byte/rx_en start a byte,
// ending flags the final edge (for chaining), done strobes with rx_byte.
module spi_flash_reader_shift8
    import spi_flash_reader_pkg::*;
(
    input  logic       spi_clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       rx_en,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       ending,
    output logic       done,
    output logic [7:0] rx_byte
);

    localparam logic HI_PH = 1'(BIT_CYC - 1);

    logic       active;
    logic       phase;
    logic       rx_on;
    logic [2:0] cnt;
    logic [7:0] tx_sh;
    logic [6:0] rx_sh;

    // Last high phase of bit 7: the caller may load the next byte on this
    // same edge so bytes run back to back without a bubble.
    assign ending = active && (phase == HI_PH) && (cnt == 3'd7);

    always_ff @(posedge spi_clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b0;
            phase   <= 1'b0;
            rx_on   <= 1'b0;
            cnt     <= 3'd0;
            tx_sh   <= 8'h00;
            rx_sh   <= 7'h00;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            done    <= 1'b0;
            rx_byte <= 8'h00;
        end else begin
            done <= 1'b0;
            if (active) begin
                if (phase == HI_PH) begin
                    // sclk falls; sample miso on this edge
                    sclk  <= 1'b0;
                    phase <= 1'b0;
                    rx_sh <= {rx_sh[5:0], miso};
                    if (cnt == 3'd7) begin
                        active <= 1'b0;
                        if (rx_on) begin
                            done    <= 1'b1;
                            rx_byte <= {rx_sh, miso};
                        end
                    end else begin
                        cnt   <= cnt + 3'd1;
                        mosi  <= tx_sh[7];
                        tx_sh <= {tx_sh[6:0], 1'b0};
                    end
                end else begin
                    sclk  <= 1'b1;
                    phase <= HI_PH;
                end
            end
            if (load) begin
                active <= 1'b1;
                phase  <= 1'b0;
                cnt    <= 3'd0;
                sclk   <= 1'b0;
                mosi   <= tx_byte[7];
                tx_sh  <= {tx_byte[6:0], 1'b0};
                rx_on  <= rx_en;
            end
        end
    end

endmodule

// File: rtl/spi_flash_reader.sv
// SPI flash burst reader: each read_flash pulse runs a READ of BURST_BYTES
// bytes at cur_addr, streaming mydata/myvalid; cur_addr advances and wraps.
// Ports: spi_clk, rst_n, read_flash, busy, flash_* SPI pins, mydata,
// myvalid, cur_addr.
module spi_flash_reader
    import spi_flash_reader_pkg::*;
#(
    parameter int          BURST_BYTES = 4,
    parameter logic [23:0] START_ADDR  = 24'h000000,
    parameter logic [23:0] ADDR_LIMIT  = 24'h100000,
    parameter int          CS_HIGH_CYC = 4,
    parameter logic [7:0]  READ_CMD    = SPI_READ_OP
) (
    input  logic        spi_clk,
    input  logic        rst_n,
    input  logic        read_flash,
    output logic        busy,
    output logic        flash_cs_n,
    output logic        flash_sclk,
    output logic        flash_mosi,
    input  logic        flash_miso,
    output logic [7:0]  mydata,
    output logic        myvalid,
    output logic [23:0] cur_addr
);

    localparam logic [7:0]  LAST_BYTE = 8'(BURST_BYTES - 1);
    localparam logic [15:0] GAP_LAST  = 16'(CS_HIGH_CYC - 1);

    // Reset asserts asynchronously, releases on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_i_n;

    always_ff @(posedge spi_clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_i_n = rst_sync[1];

    state_t      state;
    logic [7:0]  byte_cnt;
    logic [15:0] gap_cnt;

    logic        load;
    logic        rx_en;
    logic [7:0]  tx_byte;
    logic        ending;

    logic [24:0] addr_sum;
    logic [23:0] next_addr;

    // 25-bit sum so a window ending at the top of the space cannot overflow
    assign addr_sum  = {1'b0, cur_addr} + 25'(BURST_BYTES);
    assign next_addr = (addr_sum >= {1'b0, ADDR_LIMIT}) ? START_ADDR
                                                        : addr_sum[23:0];

    always_comb begin
        load    = 1'b0;
        rx_en   = 1'b0;
        tx_byte = 8'h00;
        case (state)
            ST_IDLE: begin
                if (read_flash) begin
                    load    = 1'b1;
                    tx_byte = READ_CMD;
                end
            end
            ST_CMD: begin
                if (ending) begin
                    load    = 1'b1;
                    tx_byte = cur_addr[23:16];
                end
            end
            ST_ADDR: begin
                if (ending) begin
                    load = 1'b1;
                    if (byte_cnt == 8'd0)      tx_byte = cur_addr[15:8];
                    else if (byte_cnt == 8'd1) tx_byte = cur_addr[7:0];
                    else                       rx_en   = 1'b1;
                end
            end
            ST_DATA: begin
                if (ending && (byte_cnt != LAST_BYTE)) begin
                    load  = 1'b1;
                    rx_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge spi_clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            state      <= ST_IDLE;
            byte_cnt   <= 8'd0;
            gap_cnt    <= 16'd0;
            busy       <= 1'b0;
            flash_cs_n <= 1'b1;
            cur_addr   <= START_ADDR;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (read_flash) begin
                        state      <= ST_CMD;
                        flash_cs_n <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                ST_CMD: begin
                    if (ending) begin
                        state    <= ST_ADDR;
                        byte_cnt <= 8'd0;
                    end
                end
                ST_ADDR: begin
                    if (ending) begin
                        if (byte_cnt == 8'd2) begin
                            state    <= ST_DATA;
                            byte_cnt <= 8'd0;
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (ending) begin
                        if (byte_cnt == LAST_BYTE) begin
                            state      <= ST_GAP;
                            flash_cs_n <= 1'b1;
                            gap_cnt    <= 16'd0;
                            cur_addr   <= next_addr;
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt + 16'd1;
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    spi_flash_reader_shift8 u_shift (
        .spi_clk (spi_clk),
        .rst_n   (rst_i_n),
        .load    (load),
        .rx_en   (rx_en),
        .tx_byte (tx_byte),
        .miso    (flash_miso),
        .sclk    (flash_sclk),
        .mosi    (flash_mosi),
        .ending  (ending),
        .done    (myvalid),
        .rx_byte (mydata)
    );

endmodule

// File: tb/tb_spi_flash_reader.sv
// Scoreboard bench for spi_flash_reader: two DUTs (default window and a
// window that wraps after one burst), each with a behavioural SPI flash.
module tb_spi_flash_reader;

    localparam int CS_HIGH = 4;

    typedef struct {
        logic [7:0] d;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] rf;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h000000: return 8'hA1;
            24'h000001: return 8'hB2;
            24'h000002: return 8'hC3;
            24'h000003: return 8'hD4;
            default:    return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at cyc %0d",
                     nm, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_ch
        localparam logic [23:0] SA = (g == 0) ? 24'h000000 : 24'h0FFFFC;

        logic        busy, cs_n, sclk, mosi, miso, myvalid;
        logic [7:0]  mydata;
        logic [23:0] cur_addr;

        exp_t        qb[$];
        logic [31:0] qc[$];
        exp_t        e;

        spi_flash_reader #(.START_ADDR(SA)) dut (
            .spi_clk    (clk),
            .rst_n      (rst_n),
            .read_flash (rf[g]),
            .busy       (busy),
            .flash_cs_n (cs_n),
            .flash_sclk (sclk),
            .flash_mosi (mosi),
            .flash_miso (miso),
            .mydata     (mydata),
            .myvalid    (myvalid),
            .cur_addr   (cur_addr)
        );

        // behavioural flash: samples mosi on sclk rise, drives miso on fall
        int          bitn = 0;
        logic [31:0] sr = 32'h0;
        int          dn;
        logic [7:0]  fb;

        initial miso = 1'b0;

        always @(posedge sclk or posedge cs_n) begin
            if (cs_n) begin
                bitn = 0;
            end else begin
                if (bitn < 32) sr = {sr[30:0], mosi};
                bitn++;
                if (bitn == 32) begin
                    if (qc.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL cmd_unexp: got %0h want none", sr);
                    end else begin
                        chk("cmd_addr", sr, qc.pop_front());
                    end
                end
            end
        end

        always @(negedge sclk) begin
            if (!cs_n && bitn >= 32) begin
                dn   = bitn - 32;
                fb   = flash_byte(sr[23:0] + 24'(dn / 8));
                miso = fb[7 - (dn % 8)];
            end
        end

        // monitor: data scoreboard plus SPI timing checks
        int   nv = 0, lows = 0, cs_rise = 0, last_rise = 0;
        logic rise_v = 1'b0, hv = 1'b0;
        logic psclk = 1'b0, pmosi = 1'b0, pcs = 1'b1;

        always @(negedge clk) begin
            if (myvalid) begin
                nv++;
                if (qb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexp_valid: got %0h want none", mydata);
                end else begin
                    e = qb.pop_front();
                    chk("mydata", mydata, e.d);
                    chk("valid_cyc", cyc, e.cyc);
                end
            end
            if (sclk && !psclk) begin
                if (rise_v) chk("sclk_period", cyc - last_rise, 2);
                chk("mosi_stable", mosi, pmosi);
                last_rise = cyc;
                rise_v    = 1'b1;
            end
            if (cs_n) rise_v = 1'b0;
            if (cs_n && !pcs) begin
                cs_rise = cyc;
                hv      = 1'b1;
            end
            if (!cs_n && pcs) begin
                lows++;
                if (hv && (cyc - cs_rise < CS_HIGH)) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL cs_gap: got %0d want >= %0d",
                             cyc - cs_rise, CS_HIGH);
                end
            end
            psclk = sclk;
            pmosi = mosi;
            pcs   = cs_n;
        end
    end

    task automatic burst(input int d, input logic [23:0] a,
                         input logic [31:0] bs, input int hold,
                         output int e0);
        exp_t x;
        @(negedge clk);
        e0 = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            x.d   = bs[31-8*k -: 8];
            x.cyc = e0 + 80 + 16 * k;
            if (d == 0) g_ch[0].qb.push_back(x);
            else        g_ch[1].qb.push_back(x);
        end
        if (d == 0) g_ch[0].qc.push_back({8'h03, a});
        else        g_ch[1].qc.push_back({8'h03, a});
        rf[d] = 1'b1;
        repeat (hold) @(negedge clk);
        rf[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d, output int t);
        logic b;
        t = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            b = (d == 0) ? g_ch[0].busy : g_ch[1].busy;
            if (!b) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL busy_timeout: got busy want idle, dut %0d", d);
        end
    endtask

    int e0, t, lows0, nv0;

    initial begin
        rst_n = 1'b0;
        rf    = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", g_ch[0].cs_n, 1);
        chk("rst_sclk", g_ch[0].sclk, 0);
        chk("rst_mosi", g_ch[0].mosi, 0);
        chk("rst_mydata", g_ch[0].mydata, 0);
        chk("rst_myvalid", g_ch[0].myvalid, 0);
        chk("rst_busy", g_ch[0].busy, 0);
        chk("rst_addr0", g_ch[0].cur_addr, 24'h000000);
        chk("rst_addr1", g_ch[1].cur_addr, 24'h0FFFFC);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // first burst from address 0
        burst(0, 24'h000000, 32'hA1B2C3D4, 1, e0);
        wait_idle(0, t);
        chk("busy_low_cyc", t, e0 + 132);
        chk("cs_rise_cyc", g_ch[0].cs_rise, e0 + 128);
        chk("addr_after1", g_ch[0].cur_addr, 24'h000004);

        // second burst continues at offset 4
        repeat (3) @(negedge clk);
        burst(0, 24'h000004, 32'h5E5F5C5D, 1, e0);
        wait_idle(0, t);
        chk("addr_after2", g_ch[0].cur_addr, 24'h000008);

        // held request plus pulses at E10 and in GAP, then back-to-back
        lows0 = g_ch[0].lows;
        nv0   = g_ch[0].nv;
        burst(0, 24'h000008, 32'h52535051, 5, e0);
        while (cyc < e0 + 9) @(negedge clk);
        rf[0] = 1'b1;
        @(negedge clk);
        rf[0] = 1'b0;
        while (cyc < e0 + 130) @(negedge clk);
        rf[0] = 1'b1;
        @(negedge clk);
        rf[0] = 1'b0;
        wait_idle(0, t);
        burst(0, 24'h00000C, 32'h56575455, 1, e0);
        wait_idle(0, t);
        repeat (20) @(negedge clk);
        chk("cs_low_periods", g_ch[0].lows - lows0, 2);
        chk("valid_count", g_ch[0].nv - nv0, 8);
        chk("addr_after4", g_ch[0].cur_addr, 24'h000010);

        // wrapping window: same four bytes each burst
        burst(1, 24'h0FFFFC, 32'hA6A7A4A5, 1, e0);
        wait_idle(1, t);
        chk("wrap_addr1", g_ch[1].cur_addr, 24'h0FFFFC);
        burst(1, 24'h0FFFFC, 32'hA6A7A4A5, 1, e0);
        wait_idle(1, t);
        chk("wrap_addr2", g_ch[1].cur_addr, 24'h0FFFFC);

        // reset in the middle of the address phase
        nv0 = g_ch[0].nv;
        burst(0, 24'h000010, 32'h4A4B4849, 1, e0);
        while (cyc < e0 + 40) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_cs_n", g_ch[0].cs_n, 1);
        chk("abort_sclk", g_ch[0].sclk, 0);
        chk("abort_busy", g_ch[0].busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("abort_no_valid", g_ch[0].nv - nv0, 0);
        chk("abort_qb_left", g_ch[0].qb.size(), 4);
        chk("abort_qc_left", g_ch[0].qc.size(), 1);
        g_ch[0].qb.delete();
        g_ch[0].qc.delete();
        chk("abort_addr", g_ch[0].cur_addr, 24'h000000);

        // clean burst after the abort
        burst(0, 24'h000000, 32'hA1B2C3D4, 1, e0);
        wait_idle(0, t);
        chk("post_busy_cyc", t, e0 + 132);
        chk("post_addr", g_ch[0].cur_addr, 24'h000004);

        repeat (10) @(negedge clk);
        chk("qb0_empty", g_ch[0].qb.size(), 0);
        chk("qb1_empty", g_ch[1].qb.size(), 0);
        chk("qc0_empty", g_ch[0].qc.size(), 0);
        chk("qc1_empty", g_ch[1].qc.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
